// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter.
// Holds the FSM encoding, port indices and a small pointer helper.
package ram_arb_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int unsigned P0 = 0;
  localparam int unsigned P1 = 1;

  // Round-robin pointer after a grant: favour the port that lost.
  function automatic logic other_port(input logic winner);
    return ~winner;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant.
// A lone requester always wins; on contention the pointer decides.
import ram_arb_pkg::*;

module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       pointer,
  output logic [1:0] grant
);

  // Pointer is only consulted when both ports request together.
  always_comb begin
    grant     = '0;
    grant[P0] = valid[P0] & (~valid[P1] | ~pointer);
    grant[P1] = valid[P1] & (~valid[P0] |  pointer);
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM between two requesters.
// Zero-fills the RAM after reset, then grants round-robin.
import ram_arb_pkg::*;

module ram_port_arbiter #(
  parameter int A = 10,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic         req0_we,
  input  logic [A-1:0] req0_addr,
  input  logic [D-1:0] req0_wdata,
  output logic         req0_ready,
  output logic         rsp0_valid,
  output logic [D-1:0] rsp0_rdata,
  input  logic         req1_valid,
  input  logic         req1_we,
  input  logic [A-1:0] req1_addr,
  input  logic [D-1:0] req1_wdata,
  output logic         req1_ready,
  output logic         rsp1_valid,
  output logic [D-1:0] rsp1_rdata,
  output logic [A-1:0] ram_addr,
  output logic [D-1:0] ram_din,
  output logic         ram_we,
  input  logic [D-1:0] ram_dout,
  output logic         clearing
);

  // Counter is one bit wider than the address so the last
  // clear address is reached without an aliasing wrap.
  localparam logic [A:0] LAST = {1'b0, {A{1'b1}}};

  state_e     state_q, state_d;
  logic [A:0] cnt_q, cnt_d;
  logic       ptr_q, ptr_d;
  logic       rsp0_valid_q, rsp0_valid_d;
  logic       rsp1_valid_q, rsp1_valid_d;

  logic       run;
  logic       clr;
  logic [1:0] valid;
  logic [1:0] grant;

  assign run   = (state_q == ST_RUN) & ~reset;
  assign clr   = (state_q == ST_CLEAR) & ~reset;
  assign valid = {req1_valid, req0_valid} & {2{run}};

  rr_arbiter2 u_rr (
    .valid   (valid),
    .pointer (ptr_q),
    .grant   (grant)
  );

  assign req0_ready = grant[P0];
  assign req1_ready = grant[P1];
  assign clearing   = reset | (state_q == ST_CLEAR);
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_rdata = ram_dout;
  assign rsp1_rdata = ram_dout;

  // RAM-side mux: clear sweep, else the granted port, else idle.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = req0_addr;
    ram_din  = '0;
    unique case (1'b1)
      clr: begin
        ram_we   = 1'b1;
        ram_addr = cnt_q[A-1:0];
        ram_din  = '0;
      end
      grant[P0]: begin
        ram_we   = req0_we;
        ram_addr = req0_addr;
        ram_din  = req0_wdata;
      end
      grant[P1]: begin
        ram_we   = req1_we;
        ram_addr = req1_addr;
        ram_din  = req1_wdata;
      end
      default: ;
    endcase
  end

  // Next-state: clear sweep, rr pointer update, read-response flags.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    rsp0_valid_d = grant[P0] & ~req0_we;
    rsp1_valid_d = grant[P1] & ~req1_we;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (|grant) begin
          ptr_d = other_port(grant[P1]);
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_CLEAR;
      cnt_q        <= '0;
      ptr_q        <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter with a Ram_sync model.
// Directed table, corner sequences and random traffic vs a reference.
module tb_ram_port_arbiter;

  localparam int A = 4;
  localparam int D = 8;
  localparam int N = 1 << A;

  typedef struct packed {
    logic         v;
    logic         we;
    logic [A-1:0] a;
    logic [D-1:0] d;
  } req_t;

  typedef struct packed {
    req_t         r0;
    req_t         r1;
    logic         rdy0;
    logic         rdy1;
    logic         rv0;
    logic         rv1;
    logic [D-1:0] rd;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req0_we, req0_ready, rsp0_valid;
  logic [A-1:0] req0_addr;
  logic [D-1:0] req0_wdata, rsp0_rdata;
  logic         req1_valid, req1_we, req1_ready, rsp1_valid;
  logic [A-1:0] req1_addr;
  logic [D-1:0] req1_wdata, rsp1_rdata;
  logic [A-1:0] ram_addr;
  logic [D-1:0] ram_din, ram_dout;
  logic         ram_we, clearing;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.A(A), .D(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_ready (req0_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .req1_valid (req1_valid),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_ready (req1_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we     (ram_we),
    .ram_dout   (ram_dout),
    .clearing   (clearing)
  );

  // Ram_sync: registered read, write-first.
  logic [D-1:0] mem [N] = '{default: 8'hFF};
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      ram_dout      <= ram_din;
    end else begin
      ram_dout <= mem[ram_addr];
    end
  end

  // Reference model state.
  bit           m_clear = 1'b1;
  int           m_cnt   = 0;
  int           m_pref  = 0;
  logic         m_rv [2] = '{1'b0, 1'b0};
  logic [D-1:0] m_rd [2] = '{8'h00, 8'h00};
  logic [D-1:0] ref_mem [N] = '{default: 8'hFF};

  logic cur_rst;
  req_t cur_r0, cur_r1;
  int   cur_win;

  function automatic req_t rd(input logic [A-1:0] a);
    req_t r;
    r.v = 1'b1; r.we = 1'b0; r.a = a; r.d = '0;
    return r;
  endfunction

  function automatic req_t wr(input logic [A-1:0] a, input logic [D-1:0] d);
    req_t r;
    r.v = 1'b1; r.we = 1'b1; r.a = a; r.d = d;
    return r;
  endfunction

  function automatic req_t idle();
    return '0;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %b want %b", nm, $time, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [D-1:0] act, input logic [D-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %h want %h", nm, $time, act, exp);
    end
  endtask

  task automatic chka(input string nm, input logic [A-1:0] act, input logic [A-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Drive one cycle's inputs and compare outputs mid-cycle.
  task automatic drive_and_check(input logic rst, input req_t r0, input req_t r1);
    logic exp_we;
    req_t w;
    cur_rst = rst; cur_r0 = r0; cur_r1 = r1;
    reset = rst;
    {req0_valid, req0_we, req0_addr, req0_wdata} = r0;
    {req1_valid, req1_we, req1_addr, req1_wdata} = r1;
    #4;
    cur_win = -1;
    if (!rst && !m_clear) begin
      if (r0.v && r1.v) cur_win = m_pref;
      else if (r0.v)    cur_win = 0;
      else if (r1.v)    cur_win = 1;
    end
    w = (cur_win == 1) ? r1 : r0;
    chk1("clearing", clearing, rst || m_clear);
    chk1("req0_ready", req0_ready, cur_win == 0);
    chk1("req1_ready", req1_ready, cur_win == 1);
    if (rst)          exp_we = 1'b0;
    else if (m_clear) exp_we = 1'b1;
    else              exp_we = (cur_win >= 0) && w.we;
    chk1("ram_we", ram_we, exp_we);
    if (!rst && m_clear) begin
      chka("clr_addr", ram_addr, A'(m_cnt));
      chk8("clr_din", ram_din, '0);
    end else if (cur_win >= 0) begin
      chka("ram_addr", ram_addr, w.a);
      if (w.we) chk8("ram_din", ram_din, w.d);
    end
    chk1("rsp0_valid", rsp0_valid, m_rv[0]);
    if (m_rv[0]) chk8("rsp0_rdata", rsp0_rdata, m_rd[0]);
    chk1("rsp1_valid", rsp1_valid, m_rv[1]);
    if (m_rv[1]) chk8("rsp1_rdata", rsp1_rdata, m_rd[1]);
  endtask

  // Advance the clock and the reference model together.
  task automatic clock_edge();
    req_t w;
    w = (cur_win == 1) ? cur_r1 : cur_r0;
    @(posedge clk);
    m_rv[0] = 1'b0;
    m_rv[1] = 1'b0;
    if (cur_rst) begin
      m_clear = 1'b1;
      m_cnt   = 0;
      m_pref  = 0;
    end else if (m_clear) begin
      ref_mem[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == N) m_clear = 1'b0;
    end else if (cur_win >= 0) begin
      if (w.we) begin
        ref_mem[w.a] = w.d;
      end else begin
        m_rv[cur_win] = 1'b1;
        m_rd[cur_win] = ref_mem[w.a];
      end
      m_pref = 1 - cur_win;
    end
    #1;
  endtask

  task automatic cycle(input logic rst, input req_t r0, input req_t r1);
    drive_and_check(rst, r0, r1);
    clock_edge();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, idle(), idle());
  endtask

  vec_t tbl [12];

  initial begin
    req_t p [2];
    int   first_acc;

    tbl[0]  = {rd(4'd5), idle(), 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = {idle(), wr(4'd3, 8'hA5), 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[2]  = {idle(), rd(4'd3), 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[3]  = {rd(4'd1), rd(4'd2), 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};
    tbl[4]  = {rd(4'd1), rd(4'd2), 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[5]  = {rd(4'd1), rd(4'd2), 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[6]  = {rd(4'd1), rd(4'd2), 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[7]  = {idle(), idle(), 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[8]  = {idle(), idle(), 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[9]  = {wr(4'd1, 8'h3C), idle(), 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[10] = {rd(4'd1), idle(), 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[11] = {idle(), idle(), 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C};

    reset = 1'b1;
    {req0_valid, req0_we, req0_addr, req0_wdata} = '0;
    {req1_valid, req1_we, req1_addr, req1_wdata} = '0;
    @(posedge clk);
    #1;

    // Reset, full zero-fill sweep, then directed table.
    cycle(1'b1, idle(), idle());
    cycle(1'b1, idle(), idle());
    idle_cycles(N);
    for (int i = 0; i < 12; i++) begin
      drive_and_check(1'b0, tbl[i].r0, tbl[i].r1);
      chk1($sformatf("tv%0d_rdy0", i), req0_ready, tbl[i].rdy0);
      chk1($sformatf("tv%0d_rdy1", i), req1_ready, tbl[i].rdy1);
      chk1($sformatf("tv%0d_rv0", i), rsp0_valid, tbl[i].rv0);
      chk1($sformatf("tv%0d_rv1", i), rsp1_valid, tbl[i].rv1);
      if (tbl[i].rv0) chk8($sformatf("tv%0d_rd0", i), rsp0_rdata, tbl[i].rd);
      if (tbl[i].rv1) chk8($sformatf("tv%0d_rd1", i), rsp1_rdata, tbl[i].rd);
      clock_edge();
    end

    // Requests held through the clear sweep.
    cycle(1'b1, idle(), idle());
    p[0] = rd(4'd5);
    p[1] = rd(4'd6);
    first_acc = -1;
    for (int i = 0; i < N + 4; i++) begin
      drive_and_check(1'b0, p[0], p[1]);
      if (cur_win >= 0 && first_acc < 0) first_acc = i;
      if (cur_win >= 0) p[cur_win] = idle();
      clock_edge();
    end
    chk1("clear_hold_len", first_acc == N, 1'b1);

    // Reset mid-clear at counter 7.
    cycle(1'b1, idle(), idle());
    idle_cycles(7);
    chka("cnt_before_rst", ram_addr, 4'd7);
    cycle(1'b1, idle(), idle());
    idle_cycles(N + 1);

    // Reset the cycle after an accepted read.
    cycle(1'b0, rd(4'd5), idle());
    cycle(1'b1, idle(), idle());
    idle_cycles(N + 1);

    // Random traffic; requesters hold until accepted.
    p[0] = idle();
    p[1] = idle();
    for (int i = 0; i < 400; i++) begin
      logic rst;
      for (int k = 0; k < 2; k++) begin
        if (!p[k].v && $urandom_range(0, 2) != 0) begin
          p[k].v  = 1'b1;
          p[k].we = 1'($urandom_range(0, 1));
          p[k].a  = A'($urandom_range(0, N - 1));
          p[k].d  = D'($urandom_range(0, 255));
        end
      end
      rst = ($urandom_range(0, 149) == 0);
      drive_and_check(rst, p[0], p[1]);
      if (cur_win >= 0) p[cur_win] = idle();
      clock_edge();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
